ps2_host_tx: RTL and testbench

PS/2 host-to-device transmitter. It sends one command byte to the mouse, for example 0xF4 to enable data reporting or 0xFF to reset. It sits beside the PS/2 mouse receiver on the same two open-drain lines and drives them through active-high pull-low enables. It runs the full request-to-send sequence, 11-bit frame shifting, device ACK check and frame timeout. A busy flag gates the receiver while a transmit is in progress.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_line_sync.sv | 31 +++
 rtl/ps2_host_tx.sv | 152 +++++++++++++++
 tb/tb_ps2_host_tx.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 host transmitter and receiver.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } state_t;

  localparam int FRAME_BITS = 10;

  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] CMD_SET_RATE = 8'hF3;
  localparam logic [7:0] RSP_ACK      = 8'hFA;

  // {stop, odd parity, data}; shifted out LSB first
  function automatic logic [FRAME_BITS-1:0] frame_of(
    input logic [7:0] b
  );
    return {1'b1, ~^b, b};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the PS/2 lines plus a falling-edge
// pulse on the clock line.
module ps2_line_sync (
  input  logic clk,
  input  logic rstn,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic clk_s,
  output logic data_s,
  output logic fclk
);

  logic [2:0] c_q;
  logic [1:0] d_q;

  // idle bus is high, so reset high to avoid a spurious edge
  always_ff @(posedge clk) begin
    if (!rstn) begin
      c_q <= '1;
      d_q <= '1;
    end else begin
      c_q <= {c_q[1:0], ps2_clk};
      d_q <= {d_q[0], ps2_data};
    end
  end

  assign clk_s  = c_q[1];
  assign data_s = d_q[1];
  assign fclk   = c_q[2] & ~c_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: request-to-send,
// 11-bit frame, ACK check and frame timeout.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int CNT_W          = 21
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_ack_err,
  output logic       tx_timeout,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  state_t state_q, state_d;

  logic [CNT_W-1:0]      cnt_q;
  logic [3:0]            bit_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic                  data_q;
  logic                  ack_err_q;
  logic                  done_q;
  logic                  ack_out_q;
  logic                  tout_q;

  logic clk_s, data_s, fclk;
  logic inhib_end, tout_hit, bus_idle, last_bit;

  ps2_line_sync u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .clk_s    (clk_s),
    .data_s   (data_s),
    .fclk     (fclk)
  );

  assign inhib_end = cnt_q == CNT_W'(INHIBIT_CYCLES - 1);
  assign tout_hit  = cnt_q == CNT_W'(TIMEOUT_CYCLES - 1);
  assign bus_idle  = clk_s & data_s;
  assign last_bit  = fclk && (bit_q == 4'(FRAME_BITS - 1));

  always_ff @(posedge clk) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (tx_valid) state_d = INHIBIT;
      INHIBIT:   if (inhib_end) state_d = RTS;
      RTS:       state_d = SEND;
      SEND: begin
        if (tout_hit)      state_d = IDLE;
        else if (last_bit) state_d = ACK;
      end
      ACK: begin
        if (tout_hit)  state_d = IDLE;
        else if (fclk) state_d = WAIT_IDLE;
      end
      WAIT_IDLE: if (bus_idle || tout_hit) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= 1'b0;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
      ack_out_q <= 1'b0;
      tout_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      tout_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (tx_valid) begin
            shift_q <= frame_of(tx_data);
            cnt_q   <= '0;
          end
        end
        INHIBIT: cnt_q <= cnt_q + CNT_W'(1);
        RTS: begin
          cnt_q  <= '0;
          bit_q  <= '0;
          data_q <= 1'b1;
        end
        SEND, ACK: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (tout_hit) begin
            tout_q <= 1'b1;
          end else if (fclk) begin
            if (state_q == SEND) begin
              data_q  <= ~shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 4'd1;
            end else begin
              ack_err_q <= data_s;
            end
          end
        end
        WAIT_IDLE: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (bus_idle) begin
            done_q    <= 1'b1;
            ack_out_q <= ack_err_q;
          end else if (tout_hit) begin
            tout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    ps2_clk_oe  = 1'b0;
    ps2_data_oe = 1'b0;
    tx_ready    = state_q == IDLE;
    busy        = state_q != IDLE;
    unique case (state_q)
      INHIBIT: ps2_clk_oe = 1'b1;
      RTS: begin
        ps2_clk_oe  = 1'b1;
        ps2_data_oe = 1'b1;
      end
      SEND:    ps2_data_oe = data_q;
      default: ;
    endcase
  end

  assign tx_done    = done_q;
  assign tx_ack_err = ack_out_q;
  assign tx_timeout = tout_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with a simple clocking device model
// on the open-drain bus.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, busy, tx_done, tx_ack_err, tx_timeout;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  wire        ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
  wire        ps2_data = ~(ps2_data_oe | dev_data_low);

  int         checks = 0;
  int         errors = 0;
  int         n;
  bit         seen;
  logic [9:0] got;

  always #5 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (20),
    .TIMEOUT_CYCLES (2000),
    .CNT_W          (21)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_ack_err  (tx_ack_err),
    .tx_timeout  (tx_timeout),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // request a byte and check the inhibit / RTS phases
  task automatic start_tx(input logic [7:0] b);
    int k;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = b;
    @(negedge clk);
    tx_valid = 1'b0;
    k = 0;
    while (ps2_clk_oe && !ps2_data_oe && k < 100) begin
      k++;
      @(negedge clk);
    end
    chk("inhibit_len", k, 20);
    chk("rts_oe", {ps2_clk_oe, ps2_data_oe}, 2'b11);
    @(negedge clk);
    chk("send_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
  endtask

  task automatic dev_bits(input int nb, output logic [9:0] g);
    g = '0;
    for (int i = 0; i < nb; i++) begin
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      g[i] = ps2_data;
      dev_clk_low = 1'b0;
    end
  endtask

  task automatic dev_ack(input bit ack);
    repeat (HALF / 2) @(negedge clk);
    dev_data_low = ack;
    repeat (HALF / 2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b0;
    if (ack) begin
      repeat (HALF / 2) @(negedge clk);
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (!tx_done && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", tx_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    chk("rst_tout", tx_timeout, 0);
    chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // enable command; a second request while busy is dropped
    start_tx(CMD_ENABLE);
    tx_valid = 1'b1;
    tx_data  = 8'hAA;
    repeat (3) @(negedge clk);
    chk("busy_ready", tx_ready, 0);
    chk("busy_flag", busy, 1);
    tx_valid = 1'b0;
    dev_bits(10, got);
    chk("frame_f4", got, 10'h2F4);
    dev_ack(1'b1);
    wait_done(n);
    chk("done_f4", tx_done, 1);
    chk("ackerr_f4", tx_ack_err, 0);
    chk("ready_f4", tx_ready, 1);
    @(negedge clk);
    chk("done_pulse", tx_done, 0);
    chk("no_restart", tx_ready, 1);

    start_tx(CMD_RESET);
    dev_bits(10, got);
    chk("frame_ff", got, 10'h3FF);
    dev_ack(1'b1);
    wait_done(n);
    chk("done_ff", tx_done, 1);
    chk("ackerr_ff", tx_ack_err, 0);

    start_tx(8'h00);
    dev_bits(10, got);
    chk("frame_00", got, 10'h300);
    dev_ack(1'b0);
    wait_done(n);
    chk("done_00", tx_done, 1);
    chk("ackerr_00", tx_ack_err, 1);

    // device never clocks
    start_tx(CMD_SET_RATE);
    n = 0;
    seen = 1'b0;
    while (!tx_timeout && n < 3000) begin
      @(negedge clk);
      n++;
      if (tx_done) seen = 1'b1;
    end
    chk("tout_cycles", n, 2000);
    chk("tout_no_done", seen, 0);
    chk("tout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("tout_ready", tx_ready, 1);
    chk("tout_ackerr_hold", tx_ack_err, 1);
    @(negedge clk);
    chk("tout_pulse", tx_timeout, 0);

    // reset during the fifth device clock
    start_tx(CMD_ENABLE);
    dev_bits(4, got);
    chk("partial_bits", got[3:0], 4'h4);
    repeat (HALF) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    chk("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    chk("mid_rst_ready", tx_ready, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", tx_done, 0);
    chk("mid_rst_ackerr", tx_ack_err, 0);
    chk("mid_rst_tout", tx_timeout, 0);
    dev_clk_low = 1'b0;
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
